ddr4_cmd_monitor: RTL

Passive checker on the DDR4 command/address bus feeding the U200 DIMM simulation model. Decodes every chip-selected command from the controller side, tracks open/closed state and ACT/PRE timing per bank, counts command types and flags protocol violations. Drives nothing on the DDR4 pins; outputs go to the testbench scoreboard only.

---
 rtl/ddr4_mon_pkg.sv | 44 ++++
 rtl/ddr4_mon_bank.sv | 43 ++++
 rtl/ddr4_cmd_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ddr4_mon_pkg.sv
// Shared command/error encodings and the DDR4 command decoder for the command-bus monitor.
package ddr4_mon_pkg;

   typedef enum logic [3:0] {
      CMD_ACT,
      CMD_RD,
      CMD_WR,
      CMD_PRE,
      CMD_REF,
      CMD_MRS,
      CMD_ZQ,
      CMD_NOP,
      CMD_RFU
   } cmd_e;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_ACT_OPEN  = 3'd1,
      ERR_RW_CLOSED = 3'd2,
      ERR_TRP       = 3'd3,
      ERR_TRCD      = 3'd4,
      ERR_REF_OPEN  = 3'd5,
      ERR_MRS_OPEN  = 3'd6,
      ERR_RFU       = 3'd7
   } err_e;

   // A deselected bus (cs_n high) decodes as NOP so callers need no separate gate.
   function automatic cmd_e ddr4_decode(input logic cs_n, input logic act_n,
                                        input logic [2:0] rcw);
      if (cs_n) return CMD_NOP;
      if (!act_n) return CMD_ACT;
      case (rcw)
         3'b100:  return CMD_WR;
         3'b101:  return CMD_RD;
         3'b010:  return CMD_PRE;
         3'b001:  return CMD_REF;
         3'b000:  return CMD_MRS;
         3'b110:  return CMD_ZQ;
         3'b111:  return CMD_NOP;
         default: return CMD_RFU;
      endcase
   endfunction

endpackage

// File: rtl/ddr4_mon_bank.sv
// One DDR4 bank: open/closed state plus a down-counter that must reach zero before the next
// timing-constrained command (RD/WR after ACT, ACT after PRE) is legal.
module ddr4_mon_bank #(
   parameter int T_RCD = 16,
   parameter int T_RP  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic act,
   input  logic rw,
   input  logic ap,
   input  logic pre,
   output logic is_open,
   output logic tmr_zero
);
   localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
   localparam logic [TW-1:0] RP_LD  = TW'(T_RP - 1);

   logic [TW-1:0] tmr;
   logic          open_q;

   // Loading T-1 on the command edge makes the command exactly T cycles later the first legal one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         open_q <= 1'b0;
         tmr    <= '0;
      end else if (act && !open_q) begin
         open_q <= 1'b1;
         tmr    <= RCD_LD;
      end else if (open_q && (pre || (rw && ap))) begin
         open_q <= 1'b0;
         tmr    <= RP_LD;
      end else if (tmr != '0) begin
         tmr <= tmr - TW'(1);
      end
   end

   assign is_open  = open_q;
   assign tmr_zero = (tmr == '0);

endmodule

// File: rtl/ddr4_cmd_monitor.sv
// Passive DDR4 command/address bus checker: decodes chip-selected commands, tracks per-bank
// state and ACT/PRE timing, keeps saturating command counts and reports protocol violations.
module ddr4_cmd_monitor
   import ddr4_mon_pkg::*;
#(
   parameter int BG_WIDTH  = 1,
   parameter int BA_WIDTH  = 2,
   parameter int T_RCD     = 16,
   parameter int T_RP      = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                                c0_ddr4_ck_t,
   input  logic                                c0_ddr4_reset_n,
   input  logic                                mon_en,
   input  logic                                mon_clr,
   input  logic                                c0_ddr4_cs_n,
   input  logic                                c0_ddr4_act_n,
   input  logic [16:0]                         c0_ddr4_adr,
   input  logic [BG_WIDTH-1:0]                 c0_ddr4_bg,
   input  logic [BA_WIDTH-1:0]                 c0_ddr4_ba,
   output logic [2**(BG_WIDTH+BA_WIDTH)-1:0]   open_mask,
   output logic [CNT_WIDTH-1:0]                cnt_act,
   output logic [CNT_WIDTH-1:0]                cnt_rd,
   output logic [CNT_WIDTH-1:0]                cnt_wr,
   output logic [CNT_WIDTH-1:0]                cnt_pre,
   output logic [CNT_WIDTH-1:0]                cnt_ref,
   output logic                                err_pulse,
   output logic [2:0]                          err_code,
   output logic [7:0]                          err_sticky
);
   localparam int BW = BG_WIDTH + BA_WIDTH;
   localparam int NB = 2**BW;

   cmd_e          cmd;
   err_e          err_nxt;
   logic [BW-1:0] bank_sel;
   logic          ap;
   logic [NB-1:0] is_open, tmr_zero, act_s, rw_s, pre_s;
   logic          unused_adr;

   assign cmd        = mon_en ? ddr4_decode(c0_ddr4_cs_n, c0_ddr4_act_n, c0_ddr4_adr[16:14])
                              : CMD_NOP;
   assign bank_sel   = {c0_ddr4_bg, c0_ddr4_ba};
   assign ap         = c0_ddr4_adr[10];
   assign unused_adr = ^{c0_ddr4_adr[13:11], c0_ddr4_adr[9:0]};

   always_comb begin
      act_s = '0;
      rw_s  = '0;
      pre_s = '0;
      case (cmd)
         CMD_ACT:        act_s[bank_sel] = 1'b1;
         CMD_RD, CMD_WR: rw_s[bank_sel]  = 1'b1;
         CMD_PRE: begin
            if (ap) pre_s = '1;
            else    pre_s[bank_sel] = 1'b1;
         end
         default: ;
      endcase
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      ddr4_mon_bank #(.T_RCD(T_RCD), .T_RP(T_RP)) u_bank (
         .clk      (c0_ddr4_ck_t),
         .rst_n    (c0_ddr4_reset_n),
         .act      (act_s[b]),
         .rw       (rw_s[b]),
         .ap       (ap),
         .pre      (pre_s[b]),
         .is_open  (is_open[b]),
         .tmr_zero (tmr_zero[b])
      );
   end

   always_comb begin
      err_nxt = ERR_NONE;
      case (cmd)
         CMD_ACT: begin
            if (is_open[bank_sel])       err_nxt = ERR_ACT_OPEN;
            else if (!tmr_zero[bank_sel]) err_nxt = ERR_TRP;
         end
         CMD_RD, CMD_WR: begin
            if (!is_open[bank_sel])      err_nxt = ERR_RW_CLOSED;
            else if (!tmr_zero[bank_sel]) err_nxt = ERR_TRCD;
         end
         CMD_REF: if (|is_open) err_nxt = ERR_REF_OPEN;
         CMD_MRS: if (|is_open) err_nxt = ERR_MRS_OPEN;
         CMD_RFU: err_nxt = ERR_RFU;
         default: ;
      endcase
   end

   assign open_mask = is_open;

   // A clear in the same cycle as a command wins: the command is neither counted nor made sticky.
   always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
      if (!c0_ddr4_reset_n) begin
         cnt_act    <= '0;
         cnt_rd     <= '0;
         cnt_wr     <= '0;
         cnt_pre    <= '0;
         cnt_ref    <= '0;
         err_pulse  <= 1'b0;
         err_code   <= 3'd0;
         err_sticky <= 8'd0;
      end else begin
         err_pulse <= (err_nxt != ERR_NONE);
         if (err_nxt != ERR_NONE) err_code <= err_nxt;
         if (mon_clr) begin
            cnt_act    <= '0;
            cnt_rd     <= '0;
            cnt_wr     <= '0;
            cnt_pre    <= '0;
            cnt_ref    <= '0;
            err_sticky <= 8'd0;
         end else begin
            if (err_nxt != ERR_NONE) err_sticky[err_nxt] <= 1'b1;
            if (cmd == CMD_ACT && cnt_act != '1) cnt_act <= cnt_act + CNT_WIDTH'(1);
            if (cmd == CMD_RD  && cnt_rd  != '1) cnt_rd  <= cnt_rd  + CNT_WIDTH'(1);
            if (cmd == CMD_WR  && cnt_wr  != '1) cnt_wr  <= cnt_wr  + CNT_WIDTH'(1);
            if (cmd == CMD_PRE && cnt_pre != '1) cnt_pre <= cnt_pre + CNT_WIDTH'(1);
            if (cmd == CMD_REF && cnt_ref != '1) cnt_ref <= cnt_ref + CNT_WIDTH'(1);
         end
      end
   end

endmodule
